// File: rtl/ysyx_22041211_csr_ctrl_pkg.sv
// Shared definitions for the ysyx_22041211 CSR access initiator:
// CSR addresses, request op encodings, mcause/mstatus constants, FSM states.
package ysyx_22041211_csr_ctrl_pkg;

  // Machine-mode CSR addresses touched by trap sequencing
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Environment call from M-mode
  localparam int MCAUSE_ECALL = 11;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4,
    OP_ILL5  = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } csr_op_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_EXEC    = 4'd1,
    S_T_EPC   = 4'd2,
    S_T_CAUSE = 4'd3,
    S_T_STAT  = 4'd4,
    S_T_VEC   = 4'd5,
    S_R_STAT  = 4'd6,
    S_R_EPC   = 4'd7,
    S_RESP    = 4'd8
  } csr_state_e;

  function automatic logic is_csrrx(input csr_op_e op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

  function automatic logic is_trap(input csr_op_e op);
    return (op == OP_ECALL) || (op == OP_MRET);
  endfunction

endpackage

// File: rtl/ysyx_22041211_csr_alu.sv
// Combinational CSR read-modify-write unit: new value and write enable
// for csrrw/csrrs/csrrc given the old CSR value and rs1.
module ysyx_22041211_csr_alu
  import ysyx_22041211_csr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  csr_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] src_i,
  input  logic                  src_zero_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o
);

  // csrrs/csrrc with rs1 = x0 are pure reads and must not write
  always_comb begin
    wdata_o = '0;
    we_o    = 1'b0;
    case (op_i)
      OP_CSRRW: begin
        wdata_o = src_i;
        we_o    = 1'b1;
      end
      OP_CSRRS: begin
        wdata_o = old_i | src_i;
        we_o    = ~src_zero_i;
      end
      OP_CSRRC: begin
        wdata_o = old_i & ~src_i;
        we_o    = ~src_zero_i;
      end
      default: begin
        wdata_o = '0;
        we_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_csr_ctrl.sv
// CSR access initiator: sequences csrrw/csrrs/csrrc, ecall and mret into
// single-port accesses of the CSR file and issues trap/return redirects.
// Optional build macro YSYX_22041211_MSTATUS_UPD_EN adds the mstatus
// read-modify-write step to ecall (T_STAT) and mret (R_STAT).
module ysyx_22041211_csr_ctrl
  import ysyx_22041211_csr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [11:0]           req_csr_addr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic                  req_src_zero,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_we,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rd_data,
  output logic                  resp_err,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc
);

  csr_state_e            state_q, state_d;
  csr_op_e               op_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic                  src_zero_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [DATA_WIDTH-1:0] alu_wdata;
  logic                  alu_we;
  logic                  accept;

  // Trap entry: stack MIE into MPIE, disable interrupts, stay in M-mode
  function automatic logic [DATA_WIDTH-1:0] mstatus_on_trap(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, MPP stays M-mode
  function automatic logic [DATA_WIDTH-1:0] mstatus_on_mret(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  ysyx_22041211_csr_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op_i       (op_q),
    .old_i      (csr_rdata),
    .src_i      (src_q),
    .src_zero_i (src_zero_q),
    .wdata_o    (alu_wdata),
    .we_o       (alu_we)
  );

  // Control state: FSM register and the latched op (reset to a benign value)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_CSRRW;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= csr_op_e'(req_op);
    end
  end

  // Request payload and captured read results; only meaningful once accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= req_csr_addr;
      src_q      <= req_src;
      src_zero_q <= req_src_zero;
      pc_q       <= req_pc;
    end
    old_q <= old_d;
    tgt_q <= tgt_d;
  end

  // Next-state and CSR-port/response drive; rst kills any write or pulse this cycle
  always_comb begin
    state_d        = state_q;
    old_d          = old_q;
    tgt_d          = tgt_q;
    csr_addr       = '0;
    csr_wdata      = '0;
    csr_we         = 1'b0;
    resp_valid     = 1'b0;
    resp_rd_data   = '0;
    resp_err       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (csr_op_e'(req_op))
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_EXEC;
            OP_ECALL: state_d = S_T_EPC;
`ifdef YSYX_22041211_MSTATUS_UPD_EN
            OP_MRET:  state_d = S_R_STAT;
`else
            OP_MRET:  state_d = S_R_EPC;
`endif
            default:  state_d = S_RESP;
          endcase
        end
      end
      S_EXEC: begin
        csr_addr  = addr_q;
        csr_wdata = alu_wdata;
        csr_we    = alu_we;
        old_d     = csr_rdata;
        state_d   = S_RESP;
      end
      S_T_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = DATA_WIDTH'(pc_q);
        csr_we    = 1'b1;
        state_d   = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = DATA_WIDTH'(MCAUSE_ECALL);
        csr_we    = 1'b1;
`ifdef YSYX_22041211_MSTATUS_UPD_EN
        state_d   = S_T_STAT;
`else
        state_d   = S_T_VEC;
`endif
      end
      S_T_STAT: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(csr_rdata);
        csr_we    = 1'b1;
        state_d   = S_T_VEC;
      end
      S_T_VEC: begin
        // Direct mode only: the mode bits are masked off the base
        csr_addr  = CSR_MTVEC;
        tgt_d     = ADDR_WIDTH'(csr_rdata & ~DATA_WIDTH'(3));
        state_d   = S_RESP;
      end
      S_R_STAT: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_mret(csr_rdata);
        csr_we    = 1'b1;
        state_d   = S_R_EPC;
      end
      S_R_EPC: begin
        csr_addr  = CSR_MEPC;
        tgt_d     = ADDR_WIDTH'(csr_rdata);
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (is_csrrx(op_q)) resp_rd_data = old_q;
        resp_err = ~is_csrrx(op_q) & ~is_trap(op_q);
        if (is_trap(op_q)) begin
          redirect_valid = 1'b1;
          redirect_pc    = tgt_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      state_d        = S_IDLE;
      csr_addr       = '0;
      csr_wdata      = '0;
      csr_we         = 1'b0;
      resp_valid     = 1'b0;
      resp_rd_data   = '0;
      resp_err       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_csr_ctrl.sv
// Testbench for ysyx_22041211_csr_ctrl: a behavioural CSR file drives
// csr_rdata; a transaction-level model predicts responses and CSR contents.
module tb_ysyx_22041211_csr_ctrl;

`ifdef YSYX_22041211_MSTATUS_UPD_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr_addr;
  logic [31:0] req_src;
  logic        req_src_zero;
  logic [31:0] req_pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        resp_valid;
  logic [31:0] resp_rd_data;
  logic        resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22041211_csr_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_csr_addr   (req_csr_addr),
    .req_src        (req_src),
    .req_src_zero   (req_src_zero),
    .req_pc         (req_pc),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_we         (csr_we),
    .csr_rdata      (csr_rdata),
    .resp_valid     (resp_valid),
    .resp_rd_data   (resp_rd_data),
    .resp_err       (resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Behavioural CSR file: combinational read, write at posedge
  logic [31:0] csrf [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          mepc_wc = 0;
  int          mcause_wc = 0;

  assign csr_rdata = csrf[csr_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_we) begin
      csrf[csr_addr] <= csr_wdata;
      wr_cnt <= wr_cnt + 1;
      if (csr_addr == 12'h341) mepc_wc <= cyc;
      if (csr_addr == 12'h342) mcause_wc <= cyc;
    end
    if (pre_we) csrf[pre_addr] <= pre_data;
  end

  // Reference view of the CSRs the bench uses
  logic [31:0] ref_csr [0:4095];
  logic [11:0] addr_list [5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge
  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_csr[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic cmp_csrs(input string tag);
    for (int i = 0; i < 5; i++)
      chk(tag, csrf[addr_list[i]], ref_csr[addr_list[i]]);
  endtask

  // One full transaction with model prediction; req_valid is held for the
  // whole busy period so an early re-accept would show up.
  task automatic run_txn(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                         input logic srcz, input logic [31:0] pc, output logic [31:0] rd_got);
    int          exp_lat, exp_wr, k, busy_ready, w0;
    logic [31:0] exp_rd, exp_pc, oldv, m;
    logic        exp_err, exp_rv, seen;
    exp_rd = 0; exp_pc = 0; exp_err = 0; exp_rv = 0; exp_wr = 0;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        exp_lat = 2;
        oldv    = ref_csr[a];
        exp_rd  = oldv;
        if (op == 3'd0) begin
          ref_csr[a] = src; exp_wr = 1;
        end else if (!srcz) begin
          ref_csr[a] = (op == 3'd1) ? (oldv | src) : (oldv & ~src);
          exp_wr = 1;
        end
      end
      3'd3: begin
        exp_lat = EN ? 5 : 4;
        exp_wr  = EN ? 3 : 2;
        exp_rv  = 1;
        ref_csr[12'h341] = pc;
        ref_csr[12'h342] = 32'd11;
        if (EN) begin
          m = ref_csr[12'h300];
          m[7] = m[3]; m[3] = 1'b0; m[12:11] = 2'b11;
          ref_csr[12'h300] = m;
        end
        exp_pc = {ref_csr[12'h305][31:2], 2'b00};
      end
      3'd4: begin
        exp_lat = EN ? 3 : 2;
        exp_wr  = EN ? 1 : 0;
        exp_rv  = 1;
        if (EN) begin
          m = ref_csr[12'h300];
          m[3] = m[7]; m[7] = 1'b1; m[12:11] = 2'b11;
          ref_csr[12'h300] = m;
        end
        exp_pc = ref_csr[12'h341];
      end
      default: begin
        exp_lat = 1;
        exp_err = 1;
      end
    endcase

    chk("ready_before", 32'(req_ready), 32'd1);
    req_op = op; req_csr_addr = a; req_src = src; req_src_zero = srcz; req_pc = pc;
    req_valid = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    k = 0; seen = 0; busy_ready = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (resp_valid) seen = 1'b1;
      else if (req_ready) busy_ready++;
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("rd_data", resp_rd_data, exp_rd);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("redir_valid", 32'(redirect_valid), 32'(exp_rv));
    chk("redir_pc", redirect_pc, exp_pc);
    chk("ready_busy", 32'(busy_ready), 32'd0);
    rd_got = resp_rd_data;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after", 32'(req_ready), 32'd1);
    chk("write_count", 32'(wr_cnt - w0), 32'(exp_wr));
    cmp_csrs("csr_state");
  endtask

  logic [31:0] rd;
  logic [31:0] pc_r;
  int          w_before, rv_cnt;

  initial begin
    addr_list[0] = 12'h300; addr_list[1] = 12'h305; addr_list[2] = 12'h340;
    addr_list[3] = 12'h341; addr_list[4] = 12'h342;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_csr_addr = '0;
    req_src = '0; req_src_zero = 1'b0; req_pc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_redir", 32'(redirect_valid), 32'd0);
    preload(12'h300, 32'h0000_1800);
    preload(12'h305, 32'h8000_0203);
    preload(12'h340, 32'hCAFE_0001);
    preload(12'h341, 32'h0000_1234);
    preload(12'h342, 32'h0000_0000);
    rst = 1'b0;
    #1 chk("ready_out_of_rst", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Directed cases
    run_txn(3'd0, 12'h341, 32'h8000_0010, 1'b0, 32'h0, rd);
    chk("rw_old_mepc", rd, 32'h0000_1234);
    chk("rw_new_mepc", csrf[12'h341], 32'h8000_0010);
    run_txn(3'd1, 12'h300, 32'h0000_0008, 1'b1, 32'h0, rd);
    chk("rs_x0_rd", rd, 32'h0000_1800);
    run_txn(3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h0, rd);
    chk("rs_new", csrf[12'h300], 32'h0000_1808);
    preload(12'h300, 32'h0000_1800);
    run_txn(3'd2, 12'h300, 32'h0000_0800, 1'b0, 32'h0, rd);
    chk("rc_new", csrf[12'h300], 32'h0000_1000);
    preload(12'h300, 32'h0000_1808);
    run_txn(3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0100, rd);
    chk("ecall_consec", 32'(mcause_wc - mepc_wc), 32'd1);
    chk("ecall_mstatus", csrf[12'h300], EN ? 32'h0000_1880 : 32'h0000_1808);
    preload(12'h300, 32'h0000_1880);
    preload(12'h341, 32'h8000_0104);
    run_txn(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, rd);
    chk("mret_mstatus", csrf[12'h300], EN ? 32'h0000_1888 : 32'h0000_1880);
    run_txn(3'd6, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0, rd);

    // Reset while an ECALL is in T_CAUSE
    ref_csr[12'h341] = 32'h8000_0400;
    req_op = 3'd3; req_pc = 32'h8000_0400; req_valid = 1'b1;
    w_before = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(csr_we), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
    rv_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
    end
    chk("rst_mid_no_resp", 32'(rv_cnt), 32'd0);
    chk("rst_mid_writes", 32'(wr_cnt - w_before), 32'd1);
    cmp_csrs("rst_mid_csrs");

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      int sel;
      logic [2:0] op;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: op = 3'd0;
        2, 3:    op = 3'd1;
        4, 5:    op = 3'd2;
        6:       op = 3'd3;
        7:       op = 3'd4;
        default: op = 3'($urandom_range(5, 7));
      endcase
      pc_r = $urandom & 32'hFFFF_FFFC;
      run_txn(op, addr_list[$urandom_range(0, 4)], $urandom,
              ($urandom_range(0, 3) == 0), pc_r, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
